nes_fb_arbiter: RTL and testbench

//  Shares one single-port 256x240 NES framebuffer RAM between the PPU pixel writer and the
//  VGA scan-out. Timing comes from the 341x525 scan counters of the VGA timing generator.
//  Two 6-bit palette indices are packed per RAM word, so scan-out needs one read per two pixels.

---
 rtl/nes_fb_pkg.sv | 24 ++
 rtl/nes_fb_wr_fifo.sv | 63 ++++++
 rtl/nes_fb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_nes_fb_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_fb_pkg.sv
// Shared types and constants for the NES framebuffer arbiter.
package nes_fb_pkg;

    localparam int FB_W     = 256;   // framebuffer width in pixels
    localparam int FB_H     = 240;   // framebuffer height in lines
    localparam int PIX_W    = 6;     // palette index width
    localparam int WORD_AW  = 15;    // RAM word address width (two pixels per word)

    localparam int ACTIVE_X = 256;   // visible pixels per VGA line
    localparam int ACTIVE_Y = 480;   // visible VGA lines (NES lines doubled)
    localparam int VBLANK_Y = 480;   // first VGA line reported as vblank to the PPU

    // One queued PPU pixel write: address {y[7:0], x[7:0]} and palette index.
    typedef struct packed {
        logic [15:0]      addr;
        logic [PIX_W-1:0] data;
    } fb_wr_t;

    // True when the pixel address falls inside the 240 stored lines.
    function automatic logic row_in_fb(input logic [15:0] addr);
        return addr[15:8] < 8'(FB_H);
    endfunction

endpackage

// File: rtl/nes_fb_wr_fifo.sv
// Synchronous FIFO buffering PPU pixel writes until a RAM write slot is free.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module nes_fb_wr_fifo
    import nes_fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   Clk,
    input  logic   Reset_n,
    input  logic   push,
    input  logic   pop,
    input  fb_wr_t wr_ent,
    output logic   full,
    output logic   empty,
    output fb_wr_t head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    fb_wr_t      mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[PW-1:0]];

    // Next-pointer computation; a push and a pop together leave the fill level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end
    end

    // Pointer registers; reset empties the queue and drops anything pending.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written so it carries no reset.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wr_ent;
        end
    end

endmodule

// File: rtl/nes_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA scan-out reads on even active x,
// queued PPU writes on every other cycle, plus the two-pixel unpacking pipe.
//
// PPU handshake: a write is accepted on a cycle where ppu_valid && ppu_ready;
// ppu_ready is simply "FIFO not full" and does not depend on ppu_valid. Offering
// ppu_valid while ppu_ready is low loses that write and sets ovf_sticky.
//
// Read timing: scan inputs at cycle S put the read address on ram_addr at T=S+1.
// ram_rdata is valid at T+1 and is latched then; pix_idx shows the even pixel at
// T+2 and the odd pixel at T+3.
module nes_fb_arbiter
    import nes_fb_pkg::*;
#(
    parameter int               FIFO_DEPTH = 16,
    parameter logic [PIX_W-1:0] BLANK_IDX  = 6'h0F
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [8:0]           scan_x,
    input  logic [9:0]           scan_y,
    input  logic                 ppu_valid,
    output logic                 ppu_ready,
    input  logic [15:0]          ppu_addr,
    input  logic [PIX_W-1:0]     ppu_data,
    input  logic                 ovf_clr,
    output logic                 ovf_sticky,
    output logic                 ppu_vblank,
    output logic [PIX_W-1:0]     pix_idx,
    output logic [WORD_AW-1:0]   ram_addr,
    output logic                 ram_we,
    output logic [1:0]           ram_be,
    output logic [2*PIX_W-1:0]   ram_wdata,
    input  logic [2*PIX_W-1:0]   ram_rdata
);

    // Slot decode
    logic   active;
    logic   rd_slot;
    logic   wr_slot;

    // FIFO interface
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    fb_wr_t fifo_in;
    fb_wr_t fifo_head;

    // RAM port registers
    logic [WORD_AW-1:0] ram_addr_q,  ram_addr_d;
    logic               ram_we_q,    ram_we_d;
    logic [1:0]         ram_be_q,    ram_be_d;
    logic [2*PIX_W-1:0] ram_wdata_q, ram_wdata_d;

    // Pixel pipe: rd_s1 marks the cycle the read address is on the RAM,
    // rd_s2 marks the cycle its data is on ram_rdata.
    logic               rd_s1_q,    rd_s1_d;
    logic               rd_s2_q,    rd_s2_d;
    logic               odd_pend_q, odd_pend_d;
    logic [PIX_W-1:0]   hi_pix_q,   hi_pix_d;
    logic [PIX_W-1:0]   pix_q,      pix_d;

    // Status flags
    logic               vblank_q,   vblank_d;
    logic               ovf_q,      ovf_d;

    assign active  = (scan_x < 9'(ACTIVE_X)) && (scan_y < 10'(ACTIVE_Y));
    assign rd_slot = active && !scan_x[0];
    assign wr_slot = !rd_slot;

    assign ppu_ready = !fifo_full;
    assign fifo_push = ppu_valid && ppu_ready;
    assign fifo_pop  = wr_slot && !fifo_empty;
    assign fifo_in   = '{addr: ppu_addr, data: ppu_data};

    nes_fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_ent  (fifo_in),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // RAM port: read address on read slots, FIFO head on write slots, idle otherwise.
    // Heads below the 240 stored lines are still popped but produce no strobe.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_be_d    = 2'b00;
        ram_wdata_d = ram_wdata_q;
        if (rd_slot) begin
            // Each NES line is shown on two VGA lines, hence y>>1.
            ram_addr_d = {scan_y[8:1], scan_x[7:1]};
        end else if (fifo_pop && row_in_fb(fifo_head.addr)) begin
            ram_addr_d  = fifo_head.addr[15:1];
            ram_we_d    = 1'b1;
            ram_be_d    = fifo_head.addr[0] ? 2'b10 : 2'b01;
            ram_wdata_d = {fifo_head.data, fifo_head.data};
        end
    end

    // Pixel unpacking: even pixel straight from the RAM word, odd pixel one cycle later.
    always_comb begin
        rd_s1_d    = rd_slot;
        rd_s2_d    = rd_s1_q;
        odd_pend_d = 1'b0;
        hi_pix_d   = hi_pix_q;
        pix_d      = BLANK_IDX;
        if (rd_s2_q) begin
            hi_pix_d   = ram_rdata[2*PIX_W-1:PIX_W];
            pix_d      = ram_rdata[PIX_W-1:0];
            odd_pend_d = 1'b1;
        end else if (odd_pend_q) begin
            pix_d = hi_pix_q;
        end
    end

    // Vblank report and overflow flag; a new overflow outranks a same-cycle clear.
    always_comb begin
        vblank_d = (scan_y >= 10'(VBLANK_Y));
        ovf_d    = ovf_q;
        if (ppu_valid && !ppu_ready) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Output and pipeline registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= 2'b00;
            ram_wdata_q <= '0;
            rd_s1_q     <= 1'b0;
            rd_s2_q     <= 1'b0;
            odd_pend_q  <= 1'b0;
            hi_pix_q    <= '0;
            pix_q       <= BLANK_IDX;
            vblank_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            rd_s1_q     <= rd_s1_d;
            rd_s2_q     <= rd_s2_d;
            odd_pend_q  <= odd_pend_d;
            hi_pix_q    <= hi_pix_d;
            pix_q       <= pix_d;
            vblank_q    <= vblank_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_be     = ram_be_q;
    assign ram_wdata  = ram_wdata_q;
    assign pix_idx    = pix_q;
    assign ppu_vblank = vblank_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_nes_fb_arbiter.sv
// Directed bench for nes_fb_arbiter with a registered 30720x12 lane-enabled RAM model.
module tb_nes_fb_arbiter;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Reset_n;
    always #5 Clk = ~Clk;

    logic [8:0]  scan_x;
    logic [9:0]  scan_y;
    logic        ppu_valid;
    logic        ppu_ready;
    logic [15:0] ppu_addr;
    logic [5:0]  ppu_data;
    logic        ovf_clr;
    logic        ovf_sticky;
    logic        ppu_vblank;
    logic [5:0]  pix_idx;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;

    nes_fb_arbiter dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .ppu_valid  (ppu_valid),
        .ppu_ready  (ppu_ready),
        .ppu_addr   (ppu_addr),
        .ppu_data   (ppu_data),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
        .ppu_vblank (ppu_vblank),
        .pix_idx    (pix_idx),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_be     (ram_be),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // ---------------- RAM model ----------------
    logic [11:0] ram [0:30719];

    always @(posedge Clk) begin
        if (ram_we && ram_addr < 15'd30720) begin
            if (ram_be[0]) ram[ram_addr][5:0]  <= ram_wdata[5:0];
            if (ram_be[1]) ram[ram_addr][11:6] <= ram_wdata[11:6];
        end
        ram_rdata <= (ram_addr < 15'd30720) ? ram[ram_addr] : 12'h000;
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [28:0] exp_q[$];   // {ram_addr, ram_be, ram_wdata} of expected writes
    logic [28:0] exp_w;
    int          we_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply scan position for one cycle; outputs are sampled 1 ns after the edge.
    task automatic step(input int x, input int y);
        scan_x = 9'(x);
        scan_y = 10'(y);
        @(posedge Clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [15:0] a, input logic [5:0] d);
        ppu_valid = v;
        ppu_addr  = a;
        ppu_data  = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] t3_data [4];
        t3_data[0] = 6'h11; t3_data[1] = 6'h22; t3_data[2] = 6'h33; t3_data[3] = 6'h04;

        Reset_n   = 1'b0;
        scan_x    = 9'd300;
        scan_y    = 10'd0;
        ovf_clr   = 1'b0;
        set_push(1'b0, 16'h0000, 6'h00);
        for (int i = 0; i < 30720; i++) ram[i] = 12'h000;
        ram[0] = 12'h2C1;

        repeat (2) @(posedge Clk);
        #1;
        check("rst_ready",  32'(ppu_ready),  32'h1);
        check("rst_ovf",    32'(ovf_sticky), 32'h0);
        check("rst_vblank", 32'(ppu_vblank), 32'h0);
        check("rst_pix",    32'(pix_idx),    32'h0F);
        check("rst_we",     32'(ram_we),     32'h0);
        check("rst_be",     32'(ram_be),     32'h0);
        check("rst_addr",   32'(ram_addr),   32'h0);
        check("rst_wdata",  32'(ram_wdata),  32'h0);
        Reset_n = 1'b1;

        // 1. Two-pixel unpack of word 0
        repeat (3) step(300, 0);
        step(0, 0);
        check("t1_rd_addr", 32'(ram_addr), 32'h0);
        check("t1_rd_we",   32'(ram_we),   32'h0);
        step(1, 0);
        step(2, 0);
        check("t1_pix_even", 32'(pix_idx), 32'h01);
        step(3, 0);
        check("t1_pix_odd", 32'(pix_idx), 32'h0B);
        step(4, 0);
        check("t1_pix_w1", 32'(pix_idx), 32'h00);

        // 2. Blanking and vblank
        repeat (5) step(300, 10);
        check("t2_hblank_pix", 32'(pix_idx),    32'h0F);
        check("t2_hblank_vb",  32'(ppu_vblank), 32'h0);
        step(10, 479);
        step(11, 479);
        step(12, 479);
        check("t2_vb_479", 32'(ppu_vblank), 32'h0);
        step(10, 480);
        check("t2_vb_480", 32'(ppu_vblank), 32'h1);
        for (int i = 1; i < 5; i++) step(10 + i, 480);
        check("t2_vblank_pix", 32'(pix_idx), 32'h0F);
        check("t2_vblank_we",  32'(ram_we),  32'h0);
        step(0, 524);
        check("t2_vb_524", 32'(ppu_vblank), 32'h1);
        step(0, 0);
        check("t2_vb_0", 32'(ppu_vblank), 32'h0);

        // 3. Four writes on line 5 during active scan of line 0
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({15'h280 + 15'(i / 2), (i % 2 == 1) ? 2'b10 : 2'b01,
                             t3_data[i], t3_data[i]});
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 4) set_push(1'b1, 16'h0500 + 16'(i), t3_data[i]);
            else       set_push(1'b0, 16'h0000, 6'h00);
            step(10 + i, 0);
            check("t3_we", 32'(ram_we), 32'((i % 2 == 1) && (i < 8)));
            if ((i % 2) == 0) begin
                check("t3_rd_addr", 32'(ram_addr), 32'((10 + i) / 2));
            end
            if (ram_we) begin
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("t3_write", 32'({ram_addr, ram_be, ram_wdata}), 32'(exp_w));
                end else begin
                    check("t3_extra_write", 32'(ram_addr), 32'h7FFF);
                end
            end
        end
        set_push(1'b0, 16'h0000, 6'h00);
        check("t3_q_left",    32'(exp_q.size()), 32'h0);
        check("t3_idle_be",   32'(ram_be),   32'h0);
        check("t3_idle_addr", 32'(ram_addr), 32'd10);
        step(300, 0);
        check("t3_ram_280", 32'(ram[15'h280]), 32'h891);
        check("t3_ram_281", 32'(ram[15'h281]), 32'h133);

        // 5. Out-of-frame write dropped; last stored line accepted
        set_push(1'b1, 16'hF000, 6'h3F);
        step(300, 0);
        set_push(1'b0, 16'h0000, 6'h00);
        step(301, 0);
        check("t5_drop_we", 32'(ram_we), 32'h0);
        step(300, 0);
        check("t5_drop_we2", 32'(ram_we), 32'h0);
        set_push(1'b1, 16'hEFFF, 6'h2A);
        step(302, 0);
        set_push(1'b0, 16'h0000, 6'h00);
        step(303, 0);
        check("t5_last_we",   32'(ram_we),    32'h1);
        check("t5_last_addr", 32'(ram_addr),  32'h77FF);
        check("t5_last_be",   32'(ram_be),    32'h2);
        check("t5_last_data", 32'(ram_wdata), 32'hAAA);
        step(300, 0);
        check("t5_ram_77ff", 32'(ram[15'h77FF]), 32'hA80);
        check("t5_ram_0",    32'(ram[0]),        32'h2C1);
        check("t5_ram_3800", 32'(ram[15'h3800]), 32'h000);

        // 4. Fill with scan frozen on an even active pixel (no write slots)
        for (int i = 0; i < 20; i++) begin
            check("t4_ready", 32'(ppu_ready), 32'(i < 16));
            set_push(1'b1, 16'h6400 + 16'(i), 6'(i + 1));
            step(0, 0);
            check("t4_ovf", 32'(ovf_sticky), 32'(i >= 16));
        end
        ovf_clr = 1'b1;
        step(0, 0);
        check("t4_set_wins", 32'(ovf_sticky), 32'h1);
        set_push(1'b0, 16'h0000, 6'h00);
        step(0, 0);
        check("t4_clr", 32'(ovf_sticky), 32'h0);
        ovf_clr = 1'b0;

        // 6. Drain 8 of 16, then reset mid-line with 8 still queued
        for (int i = 0; i < 16; i++) step(100 + i, 0);
        check("t6_ready_after_drain", 32'(ppu_ready), 32'h1);
        check("t6_pre_we", 32'(ram_we), 32'h1);
        check("t6_ram_3200", 32'(ram[15'h3200]), 32'h081);
        Reset_n = 1'b0;
        #1;
        check("t6_rst_we",    32'(ram_we),   32'h0);
        check("t6_rst_pix",   32'(pix_idx),  32'h0F);
        check("t6_rst_be",    32'(ram_be),   32'h0);
        check("t6_rst_addr",  32'(ram_addr), 32'h0);
        check("t6_rst_ready", 32'(ppu_ready), 32'h1);
        step(116, 0);
        step(117, 0);
        Reset_n = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0);
            if (ram_we) we_seen++;
        end
        check("t6_no_stale_we", 32'(we_seen), 32'h0);
        check("t6_ram_3201", 32'(ram[15'h3201]), 32'h103);
        check("t6_ram_3202", 32'(ram[15'h3202]), 32'h185);
        for (int w = 4; w < 8; w++) begin
            check("t6_ram_dropped", 32'(ram[15'h3200 + 15'(w)]), 32'h000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
